input_cond: RTL and testbench

//  Conditions the three raw player pushbuttons (left, right, fire) before the ship/bullet logic.
//  Per button: 2-FF synchronise, debounce, then turn the level into one-cycle move/fire pulses.

---
 rtl/space_pkg.sv | 31 +++
 rtl/input_cond_debounce_ch.sv | 76 +++++++
 rtl/input_cond.sv | 201 ++++++++++++++++++++
 tb/tb_input_cond.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/space_pkg.sv
// Shared definitions for the space game input path.
// Holds the default timing parameters (50 MHz system clock), the state
// encodings of the move and fire FSMs, and a small helper used to size
// counters from the largest timing parameter.
package space_pkg;

    // Default timing, in system clock cycles
    localparam int unsigned DEB_CYCLES_DEF    = 32'd500_000;
    localparam int unsigned REPEAT_DELAY_DEF  = 32'd15_000_000;
    localparam int unsigned REPEAT_PERIOD_DEF = 32'd2_500_000;
    localparam int unsigned FIRE_COOLDOWN_DEF = 32'd12_500_000;

    // Move FSM: idle, waiting for the first auto-repeat, auto-repeating
    typedef enum logic [1:0] {
        MV_IDLE   = 2'd0,
        MV_DELAY  = 2'd1,
        MV_REPEAT = 2'd2
    } mv_state_e;

    // Fire FSM: ready to accept a press, or cooling down after a shot
    typedef enum logic {
        FR_READY = 1'b0,
        FR_COOL  = 1'b1
    } fr_state_e;

    // Larger of two unsigned values, used for elaboration-time sizing
    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/input_cond_debounce_ch.sv
// debounce_ch: one pushbutton channel.
// Two-flop synchroniser followed by a stability-counter debouncer.
// The debounced level only changes after the synchronised input has
// differed from it for DEB_CYCLES consecutive cycles; any shorter glitch
// clears the counter and leaves the level alone.
// Ports:
//   clk     system clock
//   reset_n asynchronous active-low reset
//   raw     raw button, active-high, asynchronous to clk
//   lvl     debounced level (registered)
//   rise    one-cycle pulse in the first cycle lvl reads 1 (registered)
module debounce_ch
    import space_pkg::*;
#(
    parameter int unsigned DEB_CYCLES = DEB_CYCLES_DEF
) (
    input  logic clk,
    input  logic reset_n,
    input  logic raw,
    output logic lvl,
    output logic rise
);

    localparam int unsigned CW = $clog2(DEB_CYCLES);

    logic [1:0]    sync_q;
    logic          s_s;
    logic          lvl_q, lvl_d;
    logic          rise_q, rise_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // Bit 1 of the synchroniser is the only copy of the button seen downstream
    assign s_s = sync_q[1];

    // Two-flop synchroniser for the asynchronous button input
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= {sync_q[0], raw};
        end
    end

    // Stability counter: accept the new level on the DEB_CYCLES-th differing sample
    always_comb begin
        lvl_d  = lvl_q;
        cnt_d  = cnt_q;
        rise_d = 1'b0;
        if (s_s == lvl_q) begin
            cnt_d = {CW{1'b0}};
        end else if (cnt_q == CW'(DEB_CYCLES - 32'd1)) begin
            lvl_d  = s_s;
            cnt_d  = {CW{1'b0}};
            rise_d = s_s;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // Debounce state registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lvl_q  <= 1'b0;
            rise_q <= 1'b0;
            cnt_q  <= {CW{1'b0}};
        end else begin
            lvl_q  <= lvl_d;
            rise_q <= rise_d;
            cnt_q  <= cnt_d;
        end
    end

    assign lvl  = lvl_q;
    assign rise = rise_q;

endmodule

// File: rtl/input_cond.sv
// input_cond: conditions the left/right/fire pushbuttons for the ship and
// bullet logic. Each button is synchronised and debounced by a debounce_ch.
// Left/right drive a move FSM that emits a step pulse on press, then
// auto-repeats after REPEAT_DELAY and every REPEAT_PERIOD while held.
// Fire drives a one-shot with a cooldown; presses during the cooldown are
// dropped, and a fresh rising edge is needed afterwards.
// Ports:
//   clk, reset_n                      clock, asynchronous active-low reset
//   btn_left, btn_right, btn_fire     raw active-high buttons
//   left_lvl, right_lvl, fire_lvl     debounced levels
//   move_left, move_right             one-cycle step pulses (never both)
//   fire_pulse                        one-cycle launch pulse
//   fire_ready                        1 when a new fire press will be accepted
module input_cond
    import space_pkg::*;
#(
    parameter int unsigned DEB_CYCLES    = DEB_CYCLES_DEF,
    parameter int unsigned REPEAT_DELAY  = REPEAT_DELAY_DEF,
    parameter int unsigned REPEAT_PERIOD = REPEAT_PERIOD_DEF,
    parameter int unsigned FIRE_COOLDOWN = FIRE_COOLDOWN_DEF
) (
    input  logic clk,
    input  logic reset_n,
    input  logic btn_left,
    input  logic btn_right,
    input  logic btn_fire,
    output logic left_lvl,
    output logic right_lvl,
    output logic fire_lvl,
    output logic move_left,
    output logic move_right,
    output logic fire_pulse,
    output logic fire_ready
);

    // One width for both timers, large enough for the biggest reload value
    localparam int unsigned TW =
        $clog2(max_u(max_u(REPEAT_DELAY, REPEAT_PERIOD), FIRE_COOLDOWN));

    logic left_lvl_s, right_lvl_s, fire_lvl_s;
    logic fire_rise_s;
    logic left_rise_unused, right_rise_unused;

    debounce_ch #(.DEB_CYCLES(DEB_CYCLES)) u_deb_left (
        .clk     (clk),
        .reset_n (reset_n),
        .raw     (btn_left),
        .lvl     (left_lvl_s),
        .rise    (left_rise_unused)
    );

    debounce_ch #(.DEB_CYCLES(DEB_CYCLES)) u_deb_right (
        .clk     (clk),
        .reset_n (reset_n),
        .raw     (btn_right),
        .lvl     (right_lvl_s),
        .rise    (right_rise_unused)
    );

    debounce_ch #(.DEB_CYCLES(DEB_CYCLES)) u_deb_fire (
        .clk     (clk),
        .reset_n (reset_n),
        .raw     (btn_fire),
        .lvl     (fire_lvl_s),
        .rise    (fire_rise_s)
    );

    // A direction counts only when pressed alone; both held means no motion
    logic dir_l_s, dir_r_s, dir_ok_s;
    assign dir_l_s = left_lvl_s & ~right_lvl_s;
    assign dir_r_s = right_lvl_s & ~left_lvl_s;

    mv_state_e     mv_state_q, mv_state_d;
    logic [TW-1:0] mv_timer_q, mv_timer_d;
    logic          mv_dir_q, mv_dir_d;   // latched direction, 1 = right
    logic          move_left_q, move_left_d;
    logic          move_right_q, move_right_d;

    // Is the direction latched at the first pulse still the active one?
    assign dir_ok_s = mv_dir_q ? dir_r_s : dir_l_s;

    // Move FSM next state: first pulse, delay to auto-repeat, periodic repeat
    always_comb begin
        mv_state_d   = mv_state_q;
        mv_timer_d   = mv_timer_q;
        mv_dir_d     = mv_dir_q;
        move_left_d  = 1'b0;
        move_right_d = 1'b0;
        case (mv_state_q)
            MV_IDLE: begin
                if (dir_l_s || dir_r_s) begin
                    mv_dir_d     = dir_r_s;
                    move_left_d  = dir_l_s;
                    move_right_d = dir_r_s;
                    mv_timer_d   = TW'(REPEAT_DELAY - 32'd1);
                    mv_state_d   = MV_DELAY;
                end else begin
                    mv_timer_d = {TW{1'b0}};
                end
            end
            MV_DELAY, MV_REPEAT: begin
                // Release, both-held and swap all end the run here; a swap
                // then restarts from IDLE as a fresh press.
                if (!dir_ok_s) begin
                    mv_state_d = MV_IDLE;
                    mv_timer_d = {TW{1'b0}};
                end else if (mv_timer_q == {TW{1'b0}}) begin
                    move_left_d  = ~mv_dir_q;
                    move_right_d = mv_dir_q;
                    mv_timer_d   = TW'(REPEAT_PERIOD - 32'd1);
                    mv_state_d   = MV_REPEAT;
                end else begin
                    mv_timer_d = mv_timer_q - TW'(1);
                end
            end
            default: begin
                mv_state_d = MV_IDLE;
                mv_timer_d = {TW{1'b0}};
            end
        endcase
    end

    // Move FSM registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mv_state_q   <= MV_IDLE;
            mv_timer_q   <= {TW{1'b0}};
            mv_dir_q     <= 1'b0;
            move_left_q  <= 1'b0;
            move_right_q <= 1'b0;
        end else begin
            mv_state_q   <= mv_state_d;
            mv_timer_q   <= mv_timer_d;
            mv_dir_q     <= mv_dir_d;
            move_left_q  <= move_left_d;
            move_right_q <= move_right_d;
        end
    end

    fr_state_e     fr_state_q, fr_state_d;
    logic [TW-1:0] cool_q, cool_d;
    logic          fire_pulse_q, fire_pulse_d;
    logic          fire_ready_q, fire_ready_d;

    // Fire FSM next state: a rise is only honoured in READY, never queued
    always_comb begin
        fr_state_d   = fr_state_q;
        cool_d       = cool_q;
        fire_pulse_d = 1'b0;
        fire_ready_d = fire_ready_q;
        case (fr_state_q)
            FR_READY: begin
                if (fire_rise_s) begin
                    fire_pulse_d = 1'b1;
                    cool_d       = TW'(FIRE_COOLDOWN - 32'd1);
                    fire_ready_d = 1'b0;
                    fr_state_d   = FR_COOL;
                end else begin
                    fire_ready_d = 1'b1;
                end
            end
            FR_COOL: begin
                if (cool_q == {TW{1'b0}}) begin
                    fire_ready_d = 1'b1;
                    fr_state_d   = FR_READY;
                end else begin
                    cool_d = cool_q - TW'(1);
                end
            end
            default: begin
                fr_state_d   = FR_READY;
                cool_d       = {TW{1'b0}};
                fire_ready_d = 1'b1;
            end
        endcase
    end

    // Fire FSM registers; fire_ready comes out of reset as 1
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fr_state_q   <= FR_READY;
            cool_q       <= {TW{1'b0}};
            fire_pulse_q <= 1'b0;
            fire_ready_q <= 1'b1;
        end else begin
            fr_state_q   <= fr_state_d;
            cool_q       <= cool_d;
            fire_pulse_q <= fire_pulse_d;
            fire_ready_q <= fire_ready_d;
        end
    end

    assign left_lvl   = left_lvl_s;
    assign right_lvl  = right_lvl_s;
    assign fire_lvl   = fire_lvl_s;
    assign move_left  = move_left_q;
    assign move_right = move_right_q;
    assign fire_pulse = fire_pulse_q;
    assign fire_ready = fire_ready_q;

endmodule

// File: tb/tb_input_cond.sv
// Self-checking bench for input_cond with short timing parameters.
// Directed scenarios (reset, bounce, auto-repeat, both held, fire cooldown,
// reset mid-repeat) followed by random button activity. Every cycle all
// outputs are compared against a behavioural model that works from elapsed
// times and run lengths; the directed steps add explicit timing checks.
module tb_input_cond;

    localparam int DEB = 4;
    localparam int RD  = 10;
    localparam int RP  = 5;
    localparam int FC  = 8;

    logic clk       = 1'b0;
    logic reset_n   = 1'b0;
    logic btn_left  = 1'b1;
    logic btn_right = 1'b1;
    logic btn_fire  = 1'b1;
    logic left_lvl, right_lvl, fire_lvl;
    logic move_left, move_right, fire_pulse, fire_ready;

    input_cond #(
        .DEB_CYCLES    (DEB),
        .REPEAT_DELAY  (RD),
        .REPEAT_PERIOD (RP),
        .FIRE_COOLDOWN (FC)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .btn_left   (btn_left),
        .btn_right  (btn_right),
        .btn_fire   (btn_fire),
        .left_lvl   (left_lvl),
        .right_lvl  (right_lvl),
        .fire_lvl   (fire_lvl),
        .move_left  (move_left),
        .move_right (move_right),
        .fire_pulse (fire_pulse),
        .fire_ready (fire_ready)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Model state: index 0 = left, 1 = right, 2 = fire
    bit m_d1[3];
    bit m_s[3];
    bit m_lvl[3];
    int m_run[3];
    bit m_fire_prev;
    bit m_active;
    bit m_dir;
    int m_t0;
    int m_last_fire;
    bit e_ml, e_mr, e_fp, e_fr;

    task automatic chk(input string tag, input logic got, input logic exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s cycle %0d: observed %b expected %b", tag, cyc, got, exp);
        end
    endtask

    task automatic chk_int(input string tag, input int got, input int exp);
        checks++;
        assert (got == exp) else begin
            errors++;
            $error("FAIL %s cycle %0d: observed %0d expected %0d", tag, cyc, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < 3; c++) begin
            m_d1[c] = 1'b0; m_s[c] = 1'b0; m_lvl[c] = 1'b0; m_run[c] = 0;
        end
        m_fire_prev = 1'b0;
        m_active    = 1'b0;
        m_dir       = 1'b0;
        m_t0        = 0;
        m_last_fire = -1000;
        e_ml = 1'b0; e_mr = 1'b0; e_fp = 1'b0; e_fr = 1'b1;
    endtask

    // Advance the model by one clock edge, using pre-edge values throughout
    task automatic model_step();
        bit raw[3];
        bit l_old, r_old, rise_old, dl, dr, ok;
        int k;
        raw[0] = btn_left; raw[1] = btn_right; raw[2] = btn_fire;
        l_old    = m_lvl[0];
        r_old    = m_lvl[1];
        rise_old = m_lvl[2] && !m_fire_prev;
        e_ml = 1'b0; e_mr = 1'b0; e_fp = 1'b0;
        // Fire: shot on a fresh rise while ready; not ready for FC cycles after
        if (rise_old && e_fr) begin
            e_fp = 1'b1;
            m_last_fire = cyc;
        end
        e_fr = (cyc - m_last_fire) >= FC;
        // Move: pulse at 0, RD, RD+RP, ... cycles after the first pulse
        dl = l_old && !r_old;
        dr = r_old && !l_old;
        if (!m_active) begin
            if (dl || dr) begin
                m_active = 1'b1; m_dir = dr; m_t0 = cyc;
                e_ml = dl; e_mr = dr;
            end
        end else begin
            ok = m_dir ? dr : dl;
            k  = cyc - m_t0;
            if (!ok) m_active = 1'b0;
            else if (k == RD || (k > RD && ((k - RD) % RP) == 0)) begin
                e_ml = !m_dir; e_mr = m_dir;
            end
        end
        m_fire_prev = m_lvl[2];
        // Debounce: level flips after DEB consecutive disagreeing samples
        for (int c = 0; c < 3; c++) begin
            if (m_s[c] != m_lvl[c]) begin
                m_run[c]++;
                if (m_run[c] == DEB) begin
                    m_lvl[c] = m_s[c];
                    m_run[c] = 0;
                end
            end else begin
                m_run[c] = 0;
            end
            m_s[c]  = m_d1[c];
            m_d1[c] = raw[c];
        end
    endtask

    task automatic check_all();
        chk("left_lvl",   left_lvl,   m_lvl[0]);
        chk("right_lvl",  right_lvl,  m_lvl[1]);
        chk("fire_lvl",   fire_lvl,   m_lvl[2]);
        chk("move_left",  move_left,  e_ml);
        chk("move_right", move_right, e_mr);
        chk("fire_pulse", fire_pulse, e_fp);
        chk("fire_ready", fire_ready, e_fr);
    endtask

    task automatic tick();
        @(posedge clk);
        cyc++;
        if (reset_n === 1'b1) model_step();
        else model_reset();
        #1;
        check_all();
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        int n;
        int nr;
        logic exp_mr;
        model_reset();

        // 1: reset with every button held
        ticks(3);
        chk("t1_reset_ready", fire_ready, 1'b1);
        chk("t1_reset_lvl", left_lvl, 1'b0);
        @(negedge clk);
        reset_n = 1'b1;
        ticks(5);
        chk("t1_lvl_early", left_lvl, 1'b0);
        tick();
        chk("t1_lvl_at_6", left_lvl, 1'b1);
        btn_left = 1'b0; btn_right = 1'b0; btn_fire = 1'b0;
        ticks(20);

        // 2: 3-cycle glitches must not pass, then a clean press
        for (int g = 0; g < 3; g++) begin
            btn_left = 1'b1; ticks(3);
            btn_left = 1'b0; ticks(3);
            chk("t2_glitch", left_lvl, 1'b0);
        end
        btn_left = 1'b1;
        ticks(5);
        chk("t2_lvl_early", left_lvl, 1'b0);
        tick();
        chk("t2_lvl_at_6", left_lvl, 1'b1);

        // 4: left repeating, right added -> silence, left released -> right
        ticks(25);
        btn_right = 1'b1;
        ticks(6);
        chk("t4_right_lvl", right_lvl, 1'b1);
        n = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            n += int'(move_left) + int'(move_right);
        end
        chk_int("t4_both_held_pulses", n, 0);
        btn_left = 1'b0;
        ticks(6);
        chk("t4_left_released", left_lvl, 1'b0);
        tick();
        chk("t4_right_takes_over", move_right, 1'b1);
        ticks(20);
        btn_right = 1'b0;
        ticks(15);

        // 3: right auto-repeat timing relative to right_lvl rising
        btn_right = 1'b1;
        ticks(6);
        chk("t3_right_lvl", right_lvl, 1'b1);
        for (int k = 1; k <= 26; k++) begin
            tick();
            exp_mr = (k == 1 || k == 11 || k == 16 || k == 21 || k == 26);
            chk("t3_move_right", move_right, exp_mr);
            chk("t3_move_left", move_left, 1'b0);
        end
        btn_right = 1'b0;
        ticks(15);

        // 5: fire, re-press inside cooldown, then hold through its end
        btn_fire = 1'b1;
        n = 0; nr = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            n  += int'(fire_pulse);
            nr += int'(!fire_ready);
            if (i == 3) btn_fire = 1'b0;
            if (i == 7) btn_fire = 1'b1;
        end
        chk_int("t5_single_shot", n, 1);
        chk_int("t5_cooldown_len", nr, 8);
        btn_fire = 1'b0;
        ticks(10);
        btn_fire = 1'b1;
        n = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            n += int'(fire_pulse);
        end
        chk_int("t5_second_shot", n, 1);
        btn_fire = 1'b0;
        ticks(15);

        // 6: reset while auto-repeating, button kept held
        btn_left = 1'b1;
        ticks(30);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        model_reset();
        check_all();
        chk("t6_async_clear", left_lvl, 1'b0);
        ticks(2);
        @(negedge clk);
        reset_n = 1'b1;
        n = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            n += int'(move_left);
        end
        chk_int("t6_quiet_after_release", n, 0);
        tick();
        chk("t6_first_pulse_at_7", move_left, 1'b1);
        btn_left = 1'b0;
        ticks(15);

        // Random button activity checked against the model every cycle
        for (int seg = 0; seg < 60; seg++) begin
            btn_left  = 1'($urandom_range(0, 1));
            btn_right = 1'($urandom_range(0, 1));
            btn_fire  = 1'($urandom_range(0, 1));
            ticks(int'($urandom_range(1, 14)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
